// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI monarch arbiter.
// Imported by the interface, the round-robin picker and the top.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } arb_state_t;

  localparam int SPI_CMD_W   = 16;
  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_NUM_REQ = 2;

  // Index width for a client number; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_arb_if.sv
// Client-side request/ack bundle plus the monarch snd/cmd/done/resp handshake.
// slave = arbiter view, master = clients and monarch view.
interface spi_arb_if
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CMD_W   = SPI_CMD_W
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CMD_W-1:0] req_cmd;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       err;
  logic [CMD_W-1:0]         resp;
  logic                     busy;
  logic                     snd;
  logic [CMD_W-1:0]         cmd;
  logic                     spi_done;
  logic [CMD_W-1:0]         spi_resp;

  modport slave (
    input  req, req_cmd, spi_done, spi_resp,
    output ack, err, resp, busy, snd, cmd
  );

  modport master (
    output req, req_cmd, spi_done, spi_resp,
    input  ack, err, resp, busy, snd, cmd
  );

endinterface

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin picker: first requester after the previous winner.
// Reusable for any shared resource with NUM_REQ clients.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_gnt,
  output logic               o_any
);

  localparam int               SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0] N_W   = SUM_W'(NUM_REQ);

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Scan last+1 .. last+NUM_REQ modulo NUM_REQ; the previous winner is checked last.
  always_comb begin
    o_gnt   = i_last;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum   = {1'b0, i_last} + SUM_W'(k);
      w_idx   = (w_sum >= N_W) ? IDX_W'(w_sum - N_W) : w_sum[IDX_W-1:0];
      o_gnt   = (!w_found && i_req[w_idx]) ? w_idx : o_gnt;
      w_found = w_found | i_req[w_idx];
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/spi_arb.sv
// Round-robin sequencer sharing one SPI monarch between NUM_REQ clients,
// with a per-transaction timeout and registered ack/err pulses.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CMD_W   = SPI_CMD_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic     clk,
  input  logic     rst,
  spi_arb_if.slave bus
);

  localparam int                 IDX_W    = idx_width(NUM_REQ);
  localparam int                 TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state, w_next;
  logic [IDX_W-1:0]   r_gnt, w_gnt, r_last, w_last, w_pick;
  logic               w_any;
  logic [CMD_W-1:0]   r_cmd, w_cmd, r_resp, w_resp;
  logic [TMR_W-1:0]   r_timer, w_timer;
  logic               r_done_ff, w_done_rise;
  logic               r_err_flag, w_err_flag;
  logic [NUM_REQ-1:0] r_ack, r_err, w_sel;
  logic               r_snd, r_busy;
  logic [CMD_W-1:0]   w_req_cmd [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
    assign w_req_cmd[gi] = bus.req_cmd[gi*CMD_W +: CMD_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_gnt  (w_pick),
    .o_any  (w_any)
  );

  // done_ff resets high so a done level already present out of reset is not an edge.
  assign w_done_rise = bus.spi_done & ~r_done_ff;
  assign w_sel       = ONE_HOT0 << r_gnt;

  // Next state and next register values; everything holds unless its state moves it.
  always_comb begin
    w_next     = r_state;
    w_gnt      = r_gnt;
    w_last     = r_last;
    w_cmd      = r_cmd;
    w_resp     = r_resp;
    w_timer    = r_timer;
    w_err_flag = r_err_flag;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next = SEND;
          w_gnt  = w_pick;
          w_cmd  = w_req_cmd[w_pick];
        end else begin
          w_next = IDLE;
        end
      end
      SEND: begin
        w_timer = '0;
        w_next  = WAIT;
      end
      WAIT: begin
        // A completion on the final timer cycle still counts as success.
        if (w_done_rise) begin
          w_resp     = bus.spi_resp;
          w_err_flag = 1'b0;
          w_next     = ACK;
        end else if (r_timer == TMR_LAST) begin
          w_resp     = '1;
          w_err_flag = 1'b1;
          w_next     = ACK;
        end else begin
          w_timer = r_timer + TMR_W'(1);
        end
      end
      ACK: begin
        w_last = r_gnt;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_last     <= LAST_RST;
      r_cmd      <= '0;
      r_resp     <= '0;
      r_timer    <= '0;
      r_done_ff  <= 1'b1;
      r_err_flag <= 1'b0;
      r_ack      <= '0;
      r_err      <= '0;
      r_snd      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_gnt      <= w_gnt;
      r_last     <= w_last;
      r_cmd      <= w_cmd;
      r_resp     <= w_resp;
      r_timer    <= w_timer;
      r_done_ff  <= bus.spi_done;
      r_err_flag <= w_err_flag;
      r_ack      <= (w_next == ACK) ? w_sel : '0;
      r_err      <= ((w_next == ACK) && w_err_flag) ? w_sel : '0;
      r_snd      <= (w_next == SEND);
      r_busy     <= (w_next != IDLE);
    end
  end

  assign bus.ack  = r_ack;
  assign bus.err  = r_err;
  assign bus.resp = r_resp;
  assign bus.busy = r_busy;
  assign bus.snd  = r_snd;
  assign bus.cmd  = r_cmd;

endmodule
